// File: rtl/enemy_hit_pkg.sv
// Shared types and default hit-box geometry for the enemy hit manager.
// Coordinates are widened to signed 12 bits so box bounds never wrap.
package enemy_hit_pkg;

    typedef enum logic [1:0] {
        DEAD  = 2'd0,
        ALIVE = 2'd1,
        BOOM  = 2'd2
    } slot_state_t;

    typedef logic signed [11:0] coord_t;

    localparam int HIT_XL_DEF = 10;
    localparam int HIT_W_DEF  = 50;
    localparam int HIT_YT_DEF = 40;
    localparam int HIT_H_DEF  = 50;

    function automatic coord_t to_coord(input logic [9:0] v);
        return coord_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: DEAD/ALIVE/BOOM state, health and explosion timer.
// Outputs are decoded from registered state so they clear on reset.
module enemy_slot
    import enemy_hit_pkg::*;
#(
    parameter int HP_W        = 3,
    parameter int BOOM_FRAMES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick_i,
    input  logic            hit_i,
    input  logic            spawn_i,
    input  logic [HP_W-1:0] spawn_hp_i,
    output logic            alive_o,
    output logic            boom_o,
    output logic            kill_o,
    output logic [HP_W-1:0] hp_o
);

    localparam int TW = $clog2(BOOM_FRAMES + 1);
    localparam logic [TW-1:0]   T_LOAD = TW'(BOOM_FRAMES);
    localparam logic [TW-1:0]   T_ONE  = TW'(1);
    localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

    slot_state_t     state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            kill_q, kill_d;

    // Next-state: spawn only from DEAD, one hp per hit, timer runs on ticks.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        timer_d = timer_q;
        kill_d  = 1'b0;
        unique case (state_q)
            DEAD: begin
                if (spawn_i && spawn_hp_i != '0) begin
                    state_d = ALIVE;
                    hp_d    = spawn_hp_i;
                end
            end
            ALIVE: begin
                if (hit_i) begin
                    hp_d = hp_q - HP_ONE;
                    if (hp_q == HP_ONE) begin
                        state_d = BOOM;
                        timer_d = T_LOAD;
                        kill_d  = 1'b1;
                    end
                end
            end
            BOOM: begin
                if (frame_tick_i) begin
                    if (timer_q == T_ONE) begin
                        state_d = DEAD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
            end
            default: begin
                state_d = DEAD;
            end
        endcase
    end

    // Slot registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DEAD;
            hp_q    <= '0;
            timer_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            timer_q <= timer_d;
            kill_q  <= kill_d;
        end
    end

    assign alive_o = (state_q == ALIVE);
    assign boom_o  = (state_q == BOOM);
    assign kill_o  = kill_q;
    assign hp_o    = hp_q;

endmodule

// File: rtl/enemy_hit_manager.sv
// Bullet-vs-enemy collision array, hit arbiter and per-slot health FSMs.
// A consumed bullet is masked for one cycle while the controller retires it.
module enemy_hit_manager
    import enemy_hit_pkg::*;
#(
    parameter int N_ENEMY     = 4,
    parameter int N_BULLET    = 8,
    parameter int HP_W        = 3,
    parameter int HIT_XL      = HIT_XL_DEF,
    parameter int HIT_W       = HIT_W_DEF,
    parameter int HIT_YT      = HIT_YT_DEF,
    parameter int HIT_H       = HIT_H_DEF,
    parameter int BOOM_FRAMES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [N_ENEMY-1:0]       spawn,
    input  logic [HP_W-1:0]          spawn_hp,
    input  logic [N_ENEMY*10-1:0]    ep_x,
    input  logic [N_ENEMY*10-1:0]    ep_y,
    input  logic [N_BULLET*10-1:0]   b_x,
    input  logic [N_BULLET*10-1:0]   b_y,
    input  logic [N_BULLET-1:0]      b_valid,
    output logic [N_BULLET-1:0]      b_consume,
    output logic [N_ENEMY-1:0]       enemy_alive,
    output logic [N_ENEMY-1:0]       boom,
    output logic [N_ENEMY-1:0]       kill,
    output logic [N_ENEMY*HP_W-1:0]  enemy_hp
);

    localparam coord_t XL = coord_t'(HIT_XL);
    localparam coord_t XW = coord_t'(HIT_W);
    localparam coord_t YT = coord_t'(HIT_YT);
    localparam coord_t YH = coord_t'(HIT_H);

    logic [N_BULLET-1:0] cons_q, cons_d;
    logic [N_ENEMY-1:0]  alive;
    logic [N_ENEMY-1:0]  hit;
    logic [N_ENEMY-1:0]  ovl [N_BULLET];

    for (genvar gj = 0; gj < N_BULLET; gj++) begin : g_bul
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enm
            coord_t bx, by, ex, ey;
            assign bx = to_coord(b_x[10*gj +: 10]);
            assign by = to_coord(b_y[10*gj +: 10]);
            assign ex = to_coord(ep_x[10*gi +: 10]);
            assign ey = to_coord(ep_y[10*gi +: 10]);
            assign ovl[gj][gi] = b_valid[gj] && alive[gi] && !cons_q[gj]
                && (ex - XL <= bx) && (bx < ex + XW)
                && (ey - YT < by) && (by < ey + YH);
        end
    end

    // Bullets in ascending order each claim their lowest unclaimed enemy.
    always_comb begin
        hit    = '0;
        cons_d = '0;
        for (int j = 0; j < N_BULLET; j++) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                if (ovl[j][i] && !hit[i] && !cons_d[j]) begin
                    hit[i]    = 1'b1;
                    cons_d[j] = 1'b1;
                end
            end
        end
    end

    // Consume pulses, which double as the next-cycle bullet mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cons_q <= '0;
        end else begin
            cons_q <= cons_d;
        end
    end

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_slot
        enemy_slot #(
            .HP_W        (HP_W),
            .BOOM_FRAMES (BOOM_FRAMES)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .frame_tick_i (frame_tick),
            .hit_i        (hit[gi]),
            .spawn_i      (spawn[gi]),
            .spawn_hp_i   (spawn_hp),
            .alive_o      (alive[gi]),
            .boom_o       (boom[gi]),
            .kill_o       (kill[gi]),
            .hp_o         (enemy_hp[gi*HP_W +: HP_W])
        );
    end

    assign enemy_alive = alive;
    assign b_consume   = cons_q;

endmodule

// File: tb/tb_enemy_hit_manager.sv
// Directed bench for enemy_hit_manager with hand-computed expectations.
// Explosion length is shortened to 4 frames to keep the run short.
module tb_enemy_hit_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [3:0]  spawn;
    logic [2:0]  spawn_hp;
    logic [39:0] ep_x, ep_y;
    logic [79:0] b_x, b_y;
    logic [7:0]  b_valid;
    logic [7:0]  b_consume;
    logic [3:0]  enemy_alive, boom, kill;
    logic [11:0] enemy_hp;

    int checks = 0;
    int errors = 0;

    enemy_hit_manager #(
        .N_ENEMY     (4),
        .N_BULLET    (8),
        .HP_W        (3),
        .BOOM_FRAMES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .spawn       (spawn),
        .spawn_hp    (spawn_hp),
        .ep_x        (ep_x),
        .ep_y        (ep_y),
        .b_x         (b_x),
        .b_y         (b_y),
        .b_valid     (b_valid),
        .b_consume   (b_consume),
        .enemy_alive (enemy_alive),
        .boom        (boom),
        .kill        (kill),
        .enemy_hp    (enemy_hp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        ep_x[10*i +: 10] = 10'(x);
        ep_y[10*i +: 10] = 10'(y);
    endtask

    task automatic set_bullet(input int j, input int x, input int y);
        b_x[10*j +: 10] = 10'(x);
        b_y[10*j +: 10] = 10'(y);
    endtask

    function automatic logic [2:0] hp_of(input int i);
        return enemy_hp[3*i +: 3];
    endfunction

    typedef struct {
        int bx;
        int by;
        logic exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{0, 11, 1'b1};
        vecs[1] = '{55, 60, 1'b0};
        vecs[2] = '{20, 10, 1'b0};
        vecs[3] = '{20, 99, 1'b1};

        rst = 1'b1;
        frame_tick = 1'b0;
        spawn = '0;
        spawn_hp = '0;
        ep_x = '0;
        ep_y = '0;
        b_x = '0;
        b_y = '0;
        b_valid = '0;
        #2;
        check("rst_consume", 32'(b_consume), 32'h0);
        check("rst_alive", 32'(enemy_alive), 32'h0);
        check("rst_boom", 32'(boom), 32'h0);
        check("rst_hp", 32'(enemy_hp), 32'h0);
        step;
        step;
        rst = 1'b0;
        step;

        // Single enemy, bullet held valid across its consume.
        set_enemy(0, 100, 100);
        spawn = 4'b0001;
        spawn_hp = 3'd3;
        step;
        spawn = '0;
        check("t1_alive", 32'(enemy_alive), 32'h1);
        check("t1_hp3", 32'(hp_of(0)), 32'd3);
        set_bullet(0, 120, 90);
        b_valid[0] = 1'b1;
        step;
        check("t1_cons1", 32'(b_consume), 32'h01);
        check("t1_hp2", 32'(hp_of(0)), 32'd2);
        step;
        check("t1_mask", 32'(b_consume), 32'h00);
        check("t1_hp2b", 32'(hp_of(0)), 32'd2);
        step;
        check("t1_cons2", 32'(b_consume), 32'h01);
        check("t1_hp1", 32'(hp_of(0)), 32'd1);
        step;
        step;
        check("t1_cons3", 32'(b_consume), 32'h01);
        check("t1_hp0", 32'(hp_of(0)), 32'd0);
        check("t1_kill", 32'(kill), 32'h1);
        check("t1_boom", 32'(boom), 32'h1);
        check("t1_dead", 32'(enemy_alive), 32'h0);
        b_valid[0] = 1'b0;
        step;
        check("t1_kill_pulse", 32'(kill), 32'h0);
        check("t1_boom_hold", 32'(boom), 32'h1);

        // Explosion lasts exactly four frame ticks.
        for (int k = 0; k < 4; k++) begin
            frame_tick = 1'b1;
            step;
            frame_tick = 1'b0;
            check($sformatf("t2_boom_%0d", k), 32'(boom[0]),
                  (k < 3) ? 32'd1 : 32'd0);
            step;
        end
        check("t2_dead", 32'(enemy_alive), 32'h0);
        set_enemy(0, 600, 400);
        spawn = 4'b0001;
        spawn_hp = 3'd4;
        step;
        spawn = '0;
        check("t2_respawn", 32'(enemy_alive[0]), 32'd1);
        check("t2_hp4", 32'(hp_of(0)), 32'd4);

        // Two bullets in one enemy: lower index first.
        set_enemy(1, 300, 300);
        spawn = 4'b0010;
        spawn_hp = 3'd2;
        step;
        spawn = '0;
        check("t3_hp2", 32'(hp_of(1)), 32'd2);
        set_bullet(2, 310, 310);
        set_bullet(5, 320, 320);
        b_valid[2] = 1'b1;
        b_valid[5] = 1'b1;
        step;
        check("t3_cons2", 32'(b_consume), 32'h04);
        check("t3_hp1", 32'(hp_of(1)), 32'd1);
        b_valid[2] = 1'b0;
        step;
        check("t3_cons5", 32'(b_consume), 32'h20);
        check("t3_kill", 32'(kill), 32'h2);
        check("t3_hp0", 32'(hp_of(1)), 32'd0);
        b_valid[5] = 1'b0;
        step;
        check("t3_idle", 32'(b_consume), 32'h00);
        check("t3_boom", 32'(boom[1]), 32'd1);

        // Overlapping enemies: one bullet damages only the lower slot.
        set_enemy(0, 200, 200);
        set_enemy(3, 200, 200);
        spawn = 4'b1000;
        spawn_hp = 3'd2;
        step;
        spawn = '0;
        check("t4_hp3_init", 32'(hp_of(3)), 32'd2);
        set_bullet(1, 210, 210);
        b_valid[1] = 1'b1;
        step;
        check("t4_cons1", 32'(b_consume), 32'h02);
        check("t4_hp0", 32'(hp_of(0)), 32'd3);
        check("t4_hp3", 32'(hp_of(3)), 32'd2);
        b_valid[1] = 1'b0;
        step;
        check("t4_hp0b", 32'(hp_of(0)), 32'd3);
        check("t4_hp3b", 32'(hp_of(3)), 32'd2);

        // Hit-box edges around an enemy near the left border.
        set_enemy(2, 5, 50);
        spawn = 4'b0100;
        spawn_hp = 3'd7;
        step;
        spawn = '0;
        check("t5_hp7", 32'(hp_of(2)), 32'd7);
        foreach (vecs[v]) begin
            set_bullet(3, vecs[v].bx, vecs[v].by);
            b_valid[3] = 1'b1;
            step;
            check($sformatf("t5_vec%0d", v), 32'(b_consume[3]),
                  32'(vecs[v].exp));
            b_valid[3] = 1'b0;
            step;
        end
        check("t5_hp5", 32'(hp_of(2)), 32'd5);

        // Drive slot 2 into BOOM, tick once, then reset mid-explosion.
        set_bullet(3, 20, 60);
        for (int k = 0; k < 5; k++) begin
            b_valid[3] = 1'b1;
            step;
            b_valid[3] = 1'b0;
            step;
        end
        check("t6_boom2", 32'(boom[2]), 32'd1);
        check("t6_hp2_0", 32'(hp_of(2)), 32'd0);
        frame_tick = 1'b1;
        step;
        frame_tick = 1'b0;
        check("t6_boom2_t3", 32'(boom[2]), 32'd1);
        b_valid[1] = 1'b1;
        step;
        check("t6_pend_cons", 32'(b_consume), 32'h02);
        check("t6_hp0_2", 32'(hp_of(0)), 32'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_cons", 32'(b_consume), 32'h0);
        check("t6_rst_alive", 32'(enemy_alive), 32'h0);
        check("t6_rst_boom", 32'(boom), 32'h0);
        check("t6_rst_kill", 32'(kill), 32'h0);
        check("t6_rst_hp", 32'(enemy_hp), 32'h0);
        b_valid = '0;
        step;
        rst = 1'b0;
        step;
        check("t6_post_boom", 32'(boom), 32'h0);
        check("t6_post_hp", 32'(enemy_hp), 32'h0);
        spawn = 4'b0100;
        spawn_hp = 3'd0;
        step;
        spawn = '0;
        check("t6_zero_spawn", 32'(enemy_alive), 32'h0);
        step;
        check("t6_still_dead", 32'(enemy_alive), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
